// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the MMIO UART subsystem (transmitter and receiver).
//   OVERSAMPLE    : tick strobes per serial bit period
//   uart_state_e  : frame state shared by both directions
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART serializer: start bit (low), DATA_BITS data bits LSB first, stop bit
// (high). Bit timing is taken from an external 16x oversampling strobe.
// Ports:
//   clk     : system clock, rising edge
//   arst_n  : asynchronous active-low reset
//   start   : send request, only honoured in IDLE
//   tick    : one-clk oversampling strobe, 16 per bit period
//   din     : word to send, captured when start is accepted
//   tx_done : one-clk pulse when the final stop tick is consumed
//   tx      : registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned STOP_BIT_TICK = 16
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 start,
    input  logic                 tick,
    input  logic [DATA_BITS-1:0] din,
    output logic                 tx_done,
    output logic                 tx
);

    // Tick counter must hold both 0..15 and 0..STOP_BIT_TICK-1.
    localparam int unsigned TW = ($clog2(STOP_BIT_TICK) > 4) ? $clog2(STOP_BIT_TICK) : 4;
    localparam int unsigned BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BIT_TICK - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    uart_state_e          r_state,    w_state_nxt;
    logic [TW-1:0]        r_tick_cnt, w_tick_cnt_nxt;
    logic [BW-1:0]        r_bit_cnt,  w_bit_cnt_nxt;
    logic [DATA_BITS-1:0] r_shreg,    w_shreg_nxt;
    logic                 r_tx,       w_tx_nxt;
    logic                 w_done;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shreg    <= w_shreg_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    // tx is registered from the current state's line level, so the line
    // lags the state by one clk and never glitches.
    always_comb begin
        w_state_nxt    = r_state;
        w_tick_cnt_nxt = r_tick_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shreg_nxt    = r_shreg;
        w_tx_nxt       = 1'b1;
        w_done         = 1'b0;

        case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                // A tick coinciding with acceptance is deliberately not counted.
                if (start) begin
                    w_shreg_nxt    = din;
                    w_tick_cnt_nxt = '0;
                    w_state_nxt    = START;
                end
            end
            START: begin
                w_tx_nxt = 1'b0;
                if (tick) begin
                    if (r_tick_cnt == BIT_LAST) begin
                        w_tick_cnt_nxt = '0;
                        w_bit_cnt_nxt  = '0;
                        w_state_nxt    = DATA;
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + TW'(1);
                    end
                end
            end
            DATA: begin
                w_tx_nxt = r_shreg[0];
                if (tick) begin
                    if (r_tick_cnt == BIT_LAST) begin
                        w_tick_cnt_nxt = '0;
                        w_shreg_nxt    = r_shreg >> 1;
                        if (r_bit_cnt == DATA_LAST) begin
                            w_state_nxt = STOP;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + BW'(1);
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + TW'(1);
                    end
                end
            end
            STOP: begin
                w_tx_nxt = 1'b1;
                if (tick) begin
                    if (r_tick_cnt == STOP_LAST) begin
                        w_done      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + TW'(1);
                    end
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign tx      = r_tx;
    assign tx_done = w_done;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Table-driven bench for uart_tx. Two instances share all stimulus: one with a
// 16-tick stop bit and one with a 32-tick stop bit. Ticks arrive every 2 clks.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       start;
    logic       tick;
    logic [7:0] din;
    logic       tx16, done16, tx32, done32;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx #(.DATA_BITS(8), .STOP_BIT_TICK(16)) dut16 (
        .clk     (clk),
        .arst_n  (arst_n),
        .start   (start),
        .tick    (tick),
        .din     (din),
        .tx_done (done16),
        .tx      (tx16)
    );

    uart_tx #(.DATA_BITS(8), .STOP_BIT_TICK(32)) dut32 (
        .clk     (clk),
        .arst_n  (arst_n),
        .start   (start),
        .tick    (tick),
        .din     (din),
        .tx_done (done32),
        .tx      (tx32)
    );

    // frame: bit i is the i-th bit on the line (start, d0..d7, stop).
    typedef struct {
        logic [7:0] din;
        logic       mid_start;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input int idx, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %b, wanted %b", nm, idx, act, exp);
        end
    endtask

    // Drive inputs at the falling edge, sample just before the rising edge.
    task automatic cyc(input logic tk, input logic st, input logic [7:0] d);
        @(negedge clk);
        tick  = tk;
        start = st;
        din   = d;
        #2;
    endtask

    // Line level expected after tick k (0-based) of a frame has been consumed.
    function automatic logic exp_tx(input logic [9:0] fr, input int k);
        if (k < 144) return fr[k/16];
        return 1'b1;
    endfunction

    initial begin
        vecs[0] = '{din: 8'hCB, mid_start: 1'b1, frame: 10'b11_1001_0110};
        vecs[1] = '{din: 8'h00, mid_start: 1'b0, frame: 10'b10_0000_0000};
        vecs[2] = '{din: 8'hFF, mid_start: 1'b0, frame: 10'b11_1111_1110};
        vecs[3] = '{din: 8'h55, mid_start: 1'b0, frame: 10'b10_1010_1010};
        vecs[4] = '{din: 8'hA5, mid_start: 1'b1, frame: 10'b11_0100_1010};

        arst_n = 1'b0;
        start  = 1'b0;
        tick   = 1'b0;
        din    = 8'h00;

        // Reset holds the line idle even with tick and start active.
        for (int i = 0; i < 6; i++) begin
            cyc(i[0], 1'b1, 8'hFF);
            chk("rst_tx16", i, tx16, 1'b1);
            chk("rst_done16", i, done16, 1'b0);
            chk("rst_tx32", i, tx32, 1'b1);
            chk("rst_done32", i, done32, 1'b0);
        end
        cyc(1'b0, 1'b0, 8'h00);
        arst_n = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);

        // Full frames on both instances.
        for (int v = 0; v < 5; v++) begin
            cyc(1'b0, 1'b1, vecs[v].din);
            chk("pre_tx16", v, tx16, 1'b1);
            for (int k = 0; k < 190; k++) begin
                logic st;
                st = vecs[v].mid_start && (k >= 50) && (k <= 52);
                cyc(1'b1, st, 8'h00);
                chk("done16", k, done16, k == 159);
                chk("done32", k, done32, k == 175);
                cyc(1'b0, st, 8'h00);
                chk("tx16", k, tx16, exp_tx(vecs[v].frame, k));
                chk("tx32", k, tx32, exp_tx(vecs[v].frame, k));
                chk("idle_done16", k, done16, 1'b0);
            end
        end

        // Back-to-back: start held across the tx_done clk of the 16-tick unit.
        cyc(1'b0, 1'b1, 8'hA5);
        for (int k = 0; k < 160; k++) begin
            logic st;
            st = (k == 159);
            cyc(1'b1, st, 8'h3C);
            chk("b2b_done_a", k, done16, k == 159);
            cyc(1'b0, st, 8'h3C);
            chk("b2b_tx_a", k, tx16, exp_tx(10'b11_0100_1010, k));
        end
        for (int k = 0; k < 170; k++) begin
            cyc(1'b1, 1'b0, 8'h00);
            chk("b2b_done_b", k, done16, k == 159);
            cyc(1'b0, 1'b0, 8'h00);
            chk("b2b_tx_b", k, tx16, exp_tx(10'b10_0111_1000, k));
        end
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, 1'b0, 8'h00);
            cyc(1'b0, 1'b0, 8'h00);
        end

        // Reset during DATA aborts immediately.
        cyc(1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 40; k++) begin
            cyc(1'b1, 1'b0, 8'h00);
            cyc(1'b0, 1'b0, 8'h00);
        end
        chk("pre_abort_tx16", 0, tx16, 1'b0);
        chk("pre_abort_tx32", 0, tx32, 1'b0);
        @(negedge clk);
        #1 arst_n = 1'b0;
        #1;
        chk("abort_tx16", 0, tx16, 1'b1);
        chk("abort_tx32", 0, tx32, 1'b1);
        chk("abort_done16", 0, done16, 1'b0);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        arst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cyc(1'b1, 1'b0, 8'h00);
            chk("post_abort_done16", k, done16, 1'b0);
            chk("post_abort_done32", k, done32, 1'b0);
            cyc(1'b0, 1'b0, 8'h00);
            chk("post_abort_tx16", k, tx16, 1'b1);
            chk("post_abort_tx32", k, tx32, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
